// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : Front-end instruction fetch. Reads a word-addressed ROM at the
//            requested pointer and returns it after FETCH_LATENCY edges
//            using an enable/busy handshake.
// Options  : IFETCH_RANGE_CHECK_EN - adds a 'fault' output and turns pointers
//            beyond the ROM into a NOP plus fault flag instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
  parameter int    WORD_SIZE     = 32,
  parameter int    MEM_DEPTH     = 64,
  parameter int    FETCH_LATENCY = 2,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [0:WORD_SIZE-1] ptr,
  input  logic                 fetch_enable,
  output logic [0:WORD_SIZE-1] inst,
  output logic                 busy
`ifdef IFETCH_RANGE_CHECK_EN
  ,
  output logic                 fault
`endif
);

  // Address width into the ROM; bit WORD_SIZE-1 is the LSB of ptr.
  localparam int AW     = $clog2(MEM_DEPTH);
  localparam int CNT_W  = (FETCH_LATENCY > 1) ? $clog2(FETCH_LATENCY) : 1;
  localparam int LSB_LO = WORD_SIZE - AW;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [0:WORD_SIZE-1] inst_d;
  logic                 busy_d;
  logic [AW-1:0]        ptr_idx;

  // ROM storage; contents are fixed at elaboration and never reset.
  logic [0:WORD_SIZE-1] rom [0:MEM_DEPTH-1];

  generate
    for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_identity_rom
      assign rom[i] = WORD_SIZE'(i);
    end
  endgenerate

  // Low AW bits of the pointer, taken from the LSB end of the [0:N] vector.
  assign ptr_idx = ptr[LSB_LO +: AW];

`ifdef IFETCH_RANGE_CHECK_EN
  logic oor_q, oor_d;
  logic fault_d;
  logic ptr_oor;

  assign ptr_oor = (ptr >= WORD_SIZE'(MEM_DEPTH));
`else
  // Upper pointer bits are deliberately ignored: addresses wrap modulo depth.
  logic unused_ptr_hi;
  assign unused_ptr_hi = ^ptr[0:LSB_LO-1];
`endif

  // Next-state and datapath decisions for the IDLE/FETCH handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    inst_d  = inst;
    busy_d  = busy;
`ifdef IFETCH_RANGE_CHECK_EN
    oor_d   = oor_q;
    fault_d = fault;
`endif
    case (state_q)
      IDLE: begin
        if (fetch_enable) begin
          if (FETCH_LATENCY == 1) begin
            // Single-edge latency: return the word on the accepting edge.
            inst_d = rom[ptr_idx];
`ifdef IFETCH_RANGE_CHECK_EN
            fault_d = ptr_oor;
            if (ptr_oor) begin
              inst_d = '0;
            end
`endif
          end else begin
            addr_d  = ptr_idx;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(FETCH_LATENCY - 1);
            state_d = FETCH;
`ifdef IFETCH_RANGE_CHECK_EN
            oor_d   = ptr_oor;
`endif
          end
        end
      end
      FETCH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          inst_d  = rom[addr_q];
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef IFETCH_RANGE_CHECK_EN
          // Out-of-range fetches still pay full latency, then yield a NOP.
          fault_d = oor_q;
          if (oor_q) begin
            inst_d = '0;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      inst    <= '0;
      busy    <= 1'b0;
`ifdef IFETCH_RANGE_CHECK_EN
      oor_q   <= 1'b0;
      fault   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst    <= inst_d;
      busy    <= busy_d;
`ifdef IFETCH_RANGE_CHECK_EN
      oor_q   <= oor_d;
      fault   <= fault_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : Directed, table-driven bench for inst_fetch_unit with the
//            default parameters (32-bit words, 64-word identity ROM,
//            latency 2). Honours IFETCH_RANGE_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [0:31] ptr;
  logic        fetch_enable;
  logic [0:31] inst;
  logic        busy;
`ifdef IFETCH_RANGE_CHECK_EN
  logic        fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_unit #(
    .WORD_SIZE    (32),
    .MEM_DEPTH    (64),
    .FETCH_LATENCY(2),
    .MEM_INIT_FILE("")
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ptr         (ptr),
    .fetch_enable(fetch_enable),
    .inst        (inst),
    .busy        (busy)
`ifdef IFETCH_RANGE_CHECK_EN
    ,
    .fault       (fault)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] p;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete handshake: raise enable, drop it once busy rises,
  // then wait (bounded) for busy to fall and check the returned word.
  task automatic do_fetch(input string name, input logic [31:0] p,
                          input logic [31:0] exp_inst, input logic exp_fault);
    int cyc;
    @(negedge clk);
    ptr          = p;
    fetch_enable = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    fetch_enable = 1'b0;
    cyc = 1;
    while (busy && cyc < 8) begin
      @(posedge clk);
      #1;
      if (busy) cyc++;
    end
    check({name, "_busy_cycles"}, cyc, 32'd1);
    check({name, "_inst"}, inst, exp_inst);
`ifdef IFETCH_RANGE_CHECK_EN
    check({name, "_fault"}, {31'd0, fault}, {31'd0, exp_fault});
`else
    if (exp_fault) check({name, "_fault_expected_without_port"}, 32'd0, 32'd1);
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    ptr          = '0;
    fetch_enable = 1'b0;

    // Handshake vectors; ptr 70 wraps to 6 unless range checking is built in.
    vecs.push_back('{"p1",  32'd1,  32'h0000_0001, 1'b0});
    vecs.push_back('{"p4",  32'd4,  32'h0000_0004, 1'b0});
    vecs.push_back('{"p20", 32'd20, 32'h0000_0014, 1'b0});
    vecs.push_back('{"p21", 32'd21, 32'h0000_0015, 1'b0});
    vecs.push_back('{"p33", 32'd33, 32'h0000_0021, 1'b0});
    vecs.push_back('{"p63", 32'd63, 32'h0000_003F, 1'b0});
    vecs.push_back('{"p0",  32'd0,  32'h0000_0000, 1'b0});
`ifdef IFETCH_RANGE_CHECK_EN
    vecs.push_back('{"p70", 32'd70, 32'h0000_0000, 1'b1});
    vecs.push_back('{"p3",  32'd3,  32'h0000_0003, 1'b0});
`else
    vecs.push_back('{"p70", 32'd70, 32'h0000_0006, 1'b0});
    vecs.push_back('{"p3",  32'd3,  32'h0000_0003, 1'b0});
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_inst", inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven handshake sequence.
    foreach (vecs[i]) begin
      do_fetch(vecs[i].name, vecs[i].p, vecs[i].exp_inst, vecs[i].exp_fault);
    end

    // Pointer change during busy must not affect the fetched word.
    @(negedge clk);
    ptr          = 32'd4;
    fetch_enable = 1'b1;
    @(posedge clk);
    #1;
    check("ptrchg_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    ptr          = 32'd9;
    fetch_enable = 1'b0;
    @(posedge clk);
    #1;
    check("ptrchg_done", {31'd0, busy}, 32'd0);
    check("ptrchg_inst", inst, 32'd4);

    // Enable held high: busy toggles 1,0,1,0 with back-to-back completions.
    @(negedge clk);
    ptr          = 32'd10;
    fetch_enable = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_busy0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    ptr = 32'd11;
    @(posedge clk);
    #1;
    check("b2b_busy1", {31'd0, busy}, 32'd0);
    check("b2b_inst1", inst, 32'd10);
    @(posedge clk);
    #1;
    check("b2b_busy2", {31'd0, busy}, 32'd1);
    check("b2b_inst_hold", inst, 32'd10);
    @(posedge clk);
    #1;
    check("b2b_busy3", {31'd0, busy}, 32'd0);
    check("b2b_inst2", inst, 32'd11);
    @(negedge clk);
    fetch_enable = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset during a fetch of ptr=20: immediate clear, no late update.
    @(negedge clk);
    ptr          = 32'd20;
    fetch_enable = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n        = 1'b0;
    fetch_enable = 1'b0;
    #1;
    check("rstmid_async_busy", {31'd0, busy}, 32'd0);
    check("rstmid_async_inst", inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rstmid_post_inst", inst, 32'd0);
      check("rstmid_post_busy", {31'd0, busy}, 32'd0);
    end

    // Fetch still works after the abort.
    do_fetch("after_rst", 32'd5, 32'h0000_0005, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
